// File: rtl/fp_compare_unit_if.sv
// Handshake bundle between the FP issue logic, the compare/min-max unit
// and the FP writeback arbiter. The unit is the slave; the issue and
// writeback side (or a testbench) is the master.
interface fp_compare_unit_if #(
    parameter int Size = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [Size-1:0] operand_a;
    logic [Size-1:0] operand_b;
    logic [2:0]      op;
    logic            out_valid;
    logic            out_ready;
    logic [Size-1:0] result;
    logic            flag_nv;

    modport master (
        output in_valid,
        output operand_a,
        output operand_b,
        output op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  flag_nv
    );

    modport slave (
        input  in_valid,
        input  operand_a,
        input  operand_b,
        input  op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output flag_nv
    );
endinterface

// File: rtl/fp_compare_unit.sv
// RISC-V F/D compare and min/max unit (FEQ, FLT, FLE, FMIN, FMAX).
// Two register stages:
//   S1 holds operands, op, comparator flags and NaN classes.
//   S2 holds the selected result and the invalid-operation flag.
// Size selects single (32) or double (64) precision; no other widths are
// meaningful because the exponent width is derived from it.
module fp_compare_unit #(
    parameter int Size = 64
) (
    input  logic             clock,
    input  logic             reset,
    fp_compare_unit_if.slave bus
);

    localparam int ExpW = (Size == 32) ? 8 : 11;
    localparam int ManW = Size - 1 - ExpW;

    localparam logic [2:0] OpFle  = 3'b000;
    localparam logic [2:0] OpFlt  = 3'b001;
    localparam logic [2:0] OpFeq  = 3'b010;
    localparam logic [2:0] OpFmin = 3'b011;
    localparam logic [2:0] OpFmax = 3'b100;

    // Quiet NaN with only the quiet bit set in the mantissa.
    localparam logic [Size-1:0] CanonNan = {1'b0, {ExpW{1'b1}}, 1'b1, {(ManW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Operand field decode and NaN classification
    // ------------------------------------------------------------------
    logic            a_sign;
    logic            b_sign;
    logic [ExpW-1:0] a_exp;
    logic [ExpW-1:0] b_exp;
    logic [ManW-1:0] a_man;
    logic [ManW-1:0] b_man;
    logic            a_nan;
    logic            b_nan;
    logic            a_snan;
    logic            b_snan;

    assign a_sign = bus.operand_a[Size-1];
    assign b_sign = bus.operand_b[Size-1];
    assign a_exp  = bus.operand_a[Size-2 -: ExpW];
    assign b_exp  = bus.operand_b[Size-2 -: ExpW];
    assign a_man  = bus.operand_a[ManW-1:0];
    assign b_man  = bus.operand_b[ManW-1:0];

    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);
    assign a_snan = a_nan && !a_man[ManW-1];
    assign b_snan = b_nan && !b_man[ManW-1];

    // ------------------------------------------------------------------
    // Floating-point comparator (less / equal / greater / unordered)
    // ------------------------------------------------------------------
    logic [Size-2:0] a_mag;
    logic [Size-2:0] b_mag;
    logic            both_zero;
    logic            mag_lt;
    logic            mag_eq;
    logic            cmp_less;
    logic            cmp_equal;
    logic            cmp_greater;
    logic            cmp_unordered;

    assign a_mag     = bus.operand_a[Size-2:0];
    assign b_mag     = bus.operand_b[Size-2:0];
    assign both_zero = (a_mag == '0) && (b_mag == '0);
    assign mag_lt    = a_mag < b_mag;
    assign mag_eq    = a_mag == b_mag;

    // Sign-magnitude ordering; zeros of either sign are equal, NaNs are unordered.
    always_comb begin
        cmp_less      = 1'b0;
        cmp_equal     = 1'b0;
        cmp_greater   = 1'b0;
        cmp_unordered = a_nan || b_nan;
        if (cmp_unordered) begin
            cmp_less = 1'b0;
        end else if (both_zero) begin
            cmp_equal = 1'b1;
        end else if (a_sign != b_sign) begin
            cmp_less    = a_sign;
            cmp_greater = b_sign;
        end else if (mag_eq) begin
            cmp_equal = 1'b1;
        end else if (!a_sign) begin
            cmp_less    = mag_lt;
            cmp_greater = !mag_lt;
        end else begin
            cmp_less    = !mag_lt;
            cmp_greater = mag_lt;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_advance;
    logic s1_load;
    logic s2_load;

    assign s2_advance   = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_advance;
    assign s1_load      = bus.in_valid && bus.in_ready;
    assign s2_load      = s1_valid && s2_advance;

    // Stage valid bits; reset drops everything in flight and masks in_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (s2_advance) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [Size-1:0] s1_a;
    logic [Size-1:0] s1_b;
    logic [2:0]      s1_op;
    logic            s1_less;
    logic            s1_equal;
    logic            s1_greater;
    logic            s1_unordered;
    logic            s1_a_nan;
    logic            s1_b_nan;
    logic            s1_a_snan;
    logic            s1_b_snan;

    // Capture operands and comparator flags when an operation is accepted.
    always_ff @(posedge clock) begin
        if (s1_load) begin
            s1_a         <= bus.operand_a;
            s1_b         <= bus.operand_b;
            s1_op        <= bus.op;
            s1_less      <= cmp_less;
            s1_equal     <= cmp_equal;
            s1_greater   <= cmp_greater;
            s1_unordered <= cmp_unordered;
            s1_a_nan     <= a_nan;
            s1_b_nan     <= b_nan;
            s1_a_snan    <= a_snan;
            s1_b_snan    <= b_snan;
        end
    end

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    logic [Size-1:0] sel_result;
    logic            sel_nv;
    logic            any_nan;
    logic            any_snan;
    logic            pick_a_min;
    logic            pick_a_max;

    assign any_nan  = s1_a_nan || s1_b_nan;
    assign any_snan = s1_a_snan || s1_b_snan;

    // On equality the sign bit breaks the tie so that -0 < +0; for any
    // other equal pair the encodings are identical and either pick is fine.
    assign pick_a_min = s1_less || (s1_equal && s1_a[Size-1]);
    assign pick_a_max = s1_greater || (s1_equal && !s1_a[Size-1]);

    // Build the write-back value and NV flag from the stage-1 flags.
    always_comb begin
        sel_result = '0;
        sel_nv     = 1'b0;
        case (s1_op)
            OpFle: begin
                sel_result[0] = (s1_less || s1_equal) && !s1_unordered;
                sel_nv        = any_nan;
            end
            OpFlt: begin
                sel_result[0] = s1_less && !s1_unordered;
                sel_nv        = any_nan;
            end
            OpFeq: begin
                sel_result[0] = s1_equal && !s1_unordered;
                sel_nv        = any_snan;
            end
            OpFmin, OpFmax: begin
                sel_nv = any_snan;
                if (s1_a_nan && s1_b_nan) begin
                    sel_result = CanonNan;
                end else if (s1_a_nan) begin
                    sel_result = s1_b;
                end else if (s1_b_nan) begin
                    sel_result = s1_a;
                end else if (s1_op == OpFmin) begin
                    sel_result = pick_a_min ? s1_a : s1_b;
                end else begin
                    sel_result = pick_a_max ? s1_a : s1_b;
                end
            end
            default: begin
                sel_result = '0;
                sel_nv     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (output)
    // ------------------------------------------------------------------
    logic [Size-1:0] s2_result;
    logic            s2_nv;

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_result <= '0;
            s2_nv     <= 1'b0;
        end else if (s2_load) begin
            s2_result <= sel_result;
            s2_nv     <= sel_nv;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.flag_nv   = s2_nv;

endmodule

// File: tb/tb_fp_compare_unit.sv
// Bench for fp_compare_unit: one single-precision and one double-precision
// instance, directed cases, backpressure, mid-flight reset and a random
// stream scored against an ordering-key reference model.
module tb_fp_compare_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fp_compare_unit_if #(.Size(32)) bus32 ();
    fp_compare_unit_if #(.Size(64)) bus64 ();

    fp_compare_unit #(.Size(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
    fp_compare_unit #(.Size(64)) dut64 (.clock(clock), .reset(reset), .bus(bus64));

    typedef struct {
        logic [63:0] res;
        logic        nv;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_nan(input bit w, input logic [63:0] x);
        if (w) return (x[62:52] == 11'h7ff) && (x[51:0] != 52'd0);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_snan(input bit w, input logic [63:0] x);
        return is_nan(w, x) && !(w ? x[51] : x[22]);
    endfunction

    function automatic bit sign_of(input bit w, input logic [63:0] x);
        return w ? x[63] : x[31];
    endfunction

    // Non-NaN values map to a signed integer key that orders like the real
    // number; both zeros map to 0.
    function automatic longint key_of(input bit w, input logic [63:0] x);
        longint mag;
        mag = w ? longint'({1'b0, x[62:0]}) : longint'({33'd0, x[30:0]});
        return sign_of(w, x) ? -mag : mag;
    endfunction

    function automatic void model(input bit w, input logic [2:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] res, output logic nv);
        bit     an, bn, asn, bsn;
        longint ka, kb;
        an  = is_nan(w, a);
        bn  = is_nan(w, b);
        asn = is_snan(w, a);
        bsn = is_snan(w, b);
        ka  = key_of(w, a);
        kb  = key_of(w, b);
        res = 64'd0;
        nv  = 1'b0;
        case (op)
            3'd0: begin res = 64'(!(an || bn) && (ka <= kb)); nv = an || bn; end
            3'd1: begin res = 64'(!(an || bn) && (ka < kb));  nv = an || bn; end
            3'd2: begin res = 64'(!(an || bn) && (ka == kb)); nv = asn || bsn; end
            3'd3, 3'd4: begin
                nv = asn || bsn;
                if (an && bn)      res = w ? 64'h7ff8000000000000 : 64'h000000007fc00000;
                else if (an)       res = b;
                else if (bn)       res = a;
                else if (ka != kb) res = (op == 3'd3) ? ((ka < kb) ? a : b) : ((ka > kb) ? a : b);
                else if (ka == 0)  res = (op == 3'd3) ? (sign_of(w, a) ? a : b) : (sign_of(w, a) ? b : a);
                else               res = a;
            end
            default: begin res = 64'd0; nv = 1'b0; end
        endcase
    endfunction

    function automatic logic [63:0] rand_val(input bit w);
        logic [63:0] v;
        int          c;
        v = {$urandom, $urandom};
        c = $urandom_range(0, 9);
        if (w) begin
            case (c)
                0: v[62:0] = 63'd0;
                1: v[62:51] = 12'hfff;
                2: begin v[62:52] = 11'h7ff; v[51] = 1'b0; if (v[50:0] == 51'd0) v[0] = 1'b1; end
                3: v[62:0] = {11'h7ff, 52'd0};
                4: v[62:52] = 11'd0;
                5: v[62:0] = {11'h400, 49'd0, v[2:0]};
                default: ;
            endcase
        end else begin
            v[63:32] = 32'd0;
            case (c)
                0: v[30:0] = 31'd0;
                1: v[30:22] = 9'h1ff;
                2: begin v[30:23] = 8'hff; v[22] = 1'b0; if (v[21:0] == 22'd0) v[0] = 1'b1; end
                3: v[30:0] = {8'hff, 23'd0};
                4: v[30:23] = 8'd0;
                5: v[30:0] = {8'h80, 20'd0, v[2:0]};
                default: ;
            endcase
        end
        return v;
    endfunction

    // ---------------- DUT access ----------------
    task automatic drive(input bit w, input logic v, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic ordy);
        if (w) begin
            bus64.in_valid = v; bus64.op = o; bus64.operand_a = a; bus64.operand_b = b;
            bus64.out_ready = ordy;
        end else begin
            bus32.in_valid = v; bus32.op = o; bus32.operand_a = a[31:0]; bus32.operand_b = b[31:0];
            bus32.out_ready = ordy;
        end
    endtask

    function automatic logic get_in_ready(input bit w);
        return w ? bus64.in_ready : bus32.in_ready;
    endfunction
    function automatic logic get_out_valid(input bit w);
        return w ? bus64.out_valid : bus32.out_valid;
    endfunction
    function automatic logic [63:0] get_result(input bit w);
        return w ? bus64.result : {32'd0, bus32.result};
    endfunction
    function automatic logic get_flag(input bit w);
        return w ? bus64.flag_nv : bus32.flag_nv;
    endfunction

    // One clock of streaming traffic, scored against the model queue.
    // Items in flight equal the queue depth, so in_ready is low only when
    // two results are pending and the consumer stalls.
    task automatic step(input bit w, input logic v, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic ordy, output bit acc, output bit dlv);
        exp_t        e;
        logic [63:0] r;
        logic        n;
        @(negedge clock);
        drive(w, v, o, a, b, ordy);
        #2;
        check("in_ready", 64'(get_in_ready(w)), 64'(!(expq.size() == 2 && !ordy)));
        acc = v && get_in_ready(w);
        dlv = get_out_valid(w) && ordy;
        if (get_out_valid(w)) begin
            if (expq.size() == 0) begin
                check("out_valid_nothing_pending", 64'(get_out_valid(w)), 64'd0);
            end else if (ordy) begin
                e = expq.pop_front();
                check("stream_result", get_result(w), e.res);
                check("stream_flag_nv", 64'(get_flag(w)), 64'(e.nv));
            end
        end
        if (acc) begin
            model(w, o, a, b, r, n);
            e.res = r;
            e.nv  = n;
            expq.push_back(e);
        end
    endtask

    // Single operation into an empty pipeline; checks latency and value.
    task automatic directed(input string tag, input bit w, input logic [2:0] o, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] exp_res, input logic exp_nv);
        @(negedge clock);
        drive(w, 1'b1, o, a, b, 1'b1);
        #2 check({tag, "_in_ready"}, 64'(get_in_ready(w)), 64'd1);
        @(negedge clock);
        drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2 check({tag, "_valid_n1"}, 64'(get_out_valid(w)), 64'd0);
        @(negedge clock);
        #2;
        check({tag, "_valid_n2"}, 64'(get_out_valid(w)), 64'd1);
        check({tag, "_result"}, get_result(w), exp_res);
        check({tag, "_flag_nv"}, 64'(get_flag(w)), 64'(exp_nv));
    endtask

    task automatic random_stream(input bit w, input int cycles);
        logic [2:0]  o;
        logic [63:0] a, b;
        bit          have, acc, dlv;
        int          c;
        have = 0;
        o = 3'd0; a = 64'd0; b = 64'd0;
        for (int i = 0; i < cycles; i++) begin
            if (!have) begin
                o = 3'($urandom_range(0, 7));
                a = rand_val(w);
                c = $urandom_range(0, 9);
                if (c < 2)       b = a;
                else if (c == 2) b = w ? {~a[63], a[62:0]} : {32'd0, ~a[31], a[30:0]};
                else             b = rand_val(w);
                have = 1;
            end
            step(w, ($urandom_range(0, 9) < 7), o, a, b, ($urandom_range(0, 9) < 7), acc, dlv);
            if (acc) have = 0;
        end
        for (int i = 0; i < 10 && expq.size() > 0; i++) step(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1, acc, dlv);
        check("random_drain_empty", 64'(expq.size()), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2:0]  bp_op [4];
        logic [63:0] bp_a  [4];
        logic [63:0] bp_b  [4];
        logic [63:0] held;
        logic        held_nv;
        bit          acc, dlv;
        int          nacc, ndel, idx;

        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        drive(1'b1, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #2;
        for (int w = 0; w < 2; w++) begin
            check("reset_out_valid", 64'(get_out_valid(w[0])), 64'd0);
            check("reset_in_ready", 64'(get_in_ready(w[0])), 64'd1);
            check("reset_result", get_result(w[0]), 64'd0);
            check("reset_flag_nv", 64'(get_flag(w[0])), 64'd0);
        end

        directed("flt32",       0, 3'd1, 64'h3f800000, 64'h40000000, 64'd1, 1'b0);
        directed("flt32_swap",  0, 3'd1, 64'h40000000, 64'h3f800000, 64'd0, 1'b0);
        directed("feq32_qnan",  0, 3'd2, 64'h7fc00000, 64'h3f800000, 64'd0, 1'b0);
        directed("fle32_qnan",  0, 3'd0, 64'h7fc00000, 64'h3f800000, 64'd0, 1'b1);
        directed("fmin64_snan", 1, 3'd3, 64'h7ff4000000000000, 64'h4000000000000000,
                 64'h4000000000000000, 1'b1);
        directed("fmax64_nans", 1, 3'd4, 64'h7ff8000000000000, 64'hfff8000000000123,
                 64'h7ff8000000000000, 1'b0);
        directed("fmin32_zero", 0, 3'd3, 64'h00000000, 64'h80000000, 64'h80000000, 1'b0);
        directed("fmax32_zero", 0, 3'd4, 64'h00000000, 64'h80000000, 64'h00000000, 1'b0);
        directed("feq32_zero",  0, 3'd2, 64'h00000000, 64'h80000000, 64'd1, 1'b0);
        directed("rsvd32",      0, 3'd6, 64'h3f800000, 64'h3f800000, 64'd0, 1'b0);

        // Backpressure: four back-to-back ops while the consumer stalls.
        bp_op[0] = 3'd0; bp_op[1] = 3'd3; bp_op[2] = 3'd4; bp_op[3] = 3'd2;
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = rand_val(1'b1);
            bp_b[i] = rand_val(1'b1);
        end
        nacc = 0;
        held = 64'd0;
        held_nv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            idx = (nacc < 4) ? nacc : 3;
            step(1'b1, (nacc < 4), bp_op[idx], bp_a[idx], bp_b[idx], 1'b0, acc, dlv);
            if (acc) nacc++;
            if (c >= 2) begin
                check("bp_out_valid", 64'(get_out_valid(1'b1)), 64'd1);
                if (c == 2) begin
                    held = get_result(1'b1);
                    held_nv = get_flag(1'b1);
                    check("bp_head_result", held, expq[0].res);
                end else begin
                    check("bp_hold_result", get_result(1'b1), held);
                    check("bp_hold_flag_nv", 64'(get_flag(1'b1)), 64'(held_nv));
                end
            end
        end
        check("bp_accepts_before_stall", 64'(nacc), 64'd2);
        ndel = 0;
        for (int c = 0; c < 30 && (nacc < 4 || expq.size() > 0); c++) begin
            idx = (nacc < 4) ? nacc : 3;
            step(1'b1, (nacc < 4), bp_op[idx], bp_a[idx], bp_b[idx], 1'b1, acc, dlv);
            if (acc) nacc++;
            if (dlv) ndel++;
        end
        check("bp_delivered", 64'(ndel), 64'd4);
        check("bp_pending_left", 64'(expq.size()), 64'd0);

        // Reset with two operations in flight.
        step(1'b1, 1'b1, 3'd1, 64'h3ff0000000000000, 64'h4000000000000000, 1'b0, acc, dlv);
        step(1'b1, 1'b1, 3'd4, 64'h3ff0000000000000, 64'h4000000000000000, 1'b0, acc, dlv);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 1'b1, 3'd2, 64'h4000000000000000, 64'h4000000000000000, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1);
        #2;
        check("midreset_out_valid", 64'(get_out_valid(1'b1)), 64'd0);
        check("midreset_in_ready", 64'(get_in_ready(1'b1)), 64'd1);
        check("midreset_result", get_result(1'b1), 64'd0);
        check("midreset_flag_nv", 64'(get_flag(1'b1)), 64'd0);
        expq.delete();
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 3'd0, 64'd0, 64'd0, 1'b1, acc, dlv);

        random_stream(1'b0, 600);
        random_stream(1'b1, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_compare_unit.md
Name: fp_compare_unit

Overview:
- Pipelined RISC-V F/D compare and min/max execution unit: FEQ, FLT, FLE, FMIN, FMAX.
- Sits in the FP execute stage. Consumes operands through a valid/ready handshake.
- Internally uses comparator_fp flags (less/equal/greater/unordered) and adds NaN/sNaN classification, signed-zero ordering, result selection and the invalid-operation (NV) flag.
- Returns results to the FP writeback arbiter through a second valid/ready handshake.

Parameters:
- Size, 64, operand width: 32 (single) or 64 (double). Other values are illegal.

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  operation presented
- in_ready  output  1  unit accepts operation this cycle
- operand_a  input  Size  rs1 value, IEEE-754 encoding
- operand_b  input  Size  rs2 value, IEEE-754 encoding
- op  input  3  000 FLE, 001 FLT, 010 FEQ, 011 FMIN, 100 FMAX, 101-111 reserved
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  Size  compare result (0/1 zero-extended) or min/max value
- flag_nv  output  1  invalid-operation exception flag for this result

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports clock, reset).
- Pipeline: two register stages, S1 (operands, op, comparator flags, NaN classes) and S2 (result, flag_nv).
- Latency: an accept in cycle N makes out_valid high in cycle N+2 when there is no backpressure.
- Throughput: one operation per cycle.
- Handshakes:
  - Transfer occurs when valid && ready at a rising edge.
  - s2_advance = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_advance.
  - in_ready is combinational from out_ready. It does not depend on in_valid.
  - While out_valid && !out_ready, result and flag_nv hold stable and no data is lost or duplicated.
  - Simultaneous accept and output in one cycle is allowed and keeps the pipeline full.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, result=0, flag_nv=0, in_ready=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight operations.
  - in_valid is ignored while reset is high.
- Classification (E = exponent field, M = mantissa field, q = MSB of M):
  - NaN: E all ones and M != 0.
  - sNaN: NaN with q=0.
- FEQ: result = equal && !unordered. flag_nv = 1 iff either operand is sNaN.
- FLT: result = less && !unordered. FLE: result = (less || equal) && !unordered.
  - For both: flag_nv = 1 iff either operand is any NaN.
- Zeros: +0 and -0 compare equal for FEQ/FLT/FLE.
- FMIN/FMAX:
  - Both operands NaN: result is the canonical NaN (32: 7fc00000; 64: 7ff8000000000000).
  - Exactly one NaN: result is the other operand.
  - Otherwise, the lesser (FMIN) or greater (FMAX) operand, with -0 ordered below +0.
  - flag_nv = 1 iff either operand is sNaN.
- Reserved op: result=0, flag_nv=0, and the operation still flows through the pipeline.
- Compare results occupy bit 0 only; bits Size-1:1 are 0.

Test Plan:
- Size=32, FLT a=3f800000 b=40000000 -> after 2 cycles out_valid=1, result=1, flag_nv=0. Swapping the operands gives result=0.
- Size=32, FEQ a=7fc00000 b=3f800000 -> result=0, flag_nv=0. FLE with the same operands -> result=0, flag_nv=1.
- Size=64, FMIN a=7ff4000000000000 (sNaN) b=4000000000000000 -> result=4000000000000000, flag_nv=1. FMAX with both operands NaN -> result=7ff8000000000000.
- Size=32, FMIN a=00000000 b=80000000 -> result=80000000. FMAX -> result=00000000. FEQ -> result=1.
- Backpressure: issue 4 back-to-back ops while out_ready=0 -> in_ready drops after 2 accepts. Holding the output shows a stable result. Raising out_ready drains all 4 results in order, none lost or duplicated.
- Assert reset with 2 ops in flight -> next cycle out_valid=0, in_ready=1, and no stale result ever appears.
